// File: rtl/sec_encoder.sv
// sec_encoder: two-stage pipelined single-error-correcting (SEC) check-bit
// generator. It has an optional one-bit fault injector, so the downstream
// corrector can be exercised with a known single-bit error.
//
// Handshake rules, identical on both sides:
//   - A transfer happens on a rising edge where valid && ready are both high.
//   - A valid source holds its payload until that transfer.
//   - in_ready depends combinationally on out_ready. A word can enter S1 on the
//     same edge that S1 moves to S2 and S2 is consumed downstream.
module sec_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        inj_en,
  input  logic [5:0]  inj_bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_check,
  output logic [15:0] word_cnt
);

  // Stage 1: raw word plus its injection request.
  logic        s1_valid_q;
  logic [31:0] s1_data_q;
  logic        s1_inj_en_q;
  logic [5:0]  s1_inj_bit_q;

  // Stage 2: finished codeword.
  logic        s2_valid_q;
  logic [31:0] s2_data_q;
  logic [7:0]  s2_check_q;
  logic [15:0] word_cnt_q;

  logic        s2_load;
  logic        accept;
  logic [7:0]  check_d;
  logic [39:0] flip_d;
  logic [31:0] s2_data_d;
  logic [7:0]  s2_check_d;

  // S2 can take a new codeword when it is empty or is being drained this edge.
  assign s2_load  = !s2_valid_q || out_ready;
  // No acceptance while reset is held.
  assign in_ready = !rst && (!s1_valid_q || s2_load);
  assign accept   = in_valid && in_ready;

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_check = s2_check_q;
  assign word_cnt  = word_cnt_q;

  // Check-bit equations. Every data bit feeds exactly three check bits, and
  // no two data bits share the same set of three. A single flip therefore
  // gives a unique, non-zero syndrome downstream.
  always_comb begin
    check_d    = '0;
    check_d[0] = (^s1_data_q[23:16]) ^ s1_data_q[0] ^ s1_data_q[4] ^ s1_data_q[8] ^ s1_data_q[12];
    check_d[1] = (^s1_data_q[31:24]) ^ s1_data_q[1] ^ s1_data_q[5] ^ s1_data_q[9] ^ s1_data_q[13];
    check_d[2] = (^s1_data_q[19:16]) ^ (^s1_data_q[27:24])
               ^ s1_data_q[2] ^ s1_data_q[6] ^ s1_data_q[10] ^ s1_data_q[14];
    check_d[3] = (^s1_data_q[23:20]) ^ (^s1_data_q[31:28])
               ^ s1_data_q[3] ^ s1_data_q[7] ^ s1_data_q[11] ^ s1_data_q[15];
    check_d[4] = (^s1_data_q[7:0])   ^ s1_data_q[16] ^ s1_data_q[20] ^ s1_data_q[24] ^ s1_data_q[28];
    check_d[5] = (^s1_data_q[15:8])  ^ s1_data_q[17] ^ s1_data_q[21] ^ s1_data_q[25] ^ s1_data_q[29];
    check_d[6] = (^s1_data_q[3:0])   ^ (^s1_data_q[11:8])
               ^ s1_data_q[18] ^ s1_data_q[22] ^ s1_data_q[26] ^ s1_data_q[30];
    check_d[7] = (^s1_data_q[7:4])   ^ (^s1_data_q[15:12])
               ^ s1_data_q[19] ^ s1_data_q[23] ^ s1_data_q[27] ^ s1_data_q[31];
  end

  // One-hot flip mask over the 40-bit codeword {check, data}.
  // Indices 40..63 never match, so they inject nothing.
  always_comb begin
    flip_d = '0;
    for (int i = 0; i < 40; i++) begin
      flip_d[i] = s1_inj_en_q && (s1_inj_bit_q == 6'(i));
    end
    s2_data_d  = s1_data_q ^ flip_d[31:0];
    s2_check_d = check_d ^ flip_d[39:32];
  end

  // Pipeline registers, stage valids and the handshake counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_inj_en_q  <= 1'b0;
      s1_inj_bit_q <= '0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_check_q   <= '0;
      word_cnt_q   <= '0;
    end else begin
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q  <= s2_data_d;
          s2_check_q <= s2_check_d;
        end
      end
      if (accept) begin
        s1_valid_q   <= 1'b1;
        s1_data_q    <= in_data;
        s1_inj_en_q  <= inj_en;
        s1_inj_bit_q <= inj_bit;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_valid_q && out_ready) begin
        word_cnt_q <= word_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sec_encoder.sv
// tb_sec_encoder: directed vectors with hand-computed codewords, followed by
// a long scoreboarded stream. The stream checks the downstream syndrome, the
// single-bit correction, output hold under stall, and the counter wrap.
module tb_sec_encoder;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        inj_en;
  logic [5:0]  inj_bit;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_check;
  logic [15:0] word_cnt;

  always #5 clk = ~clk;

  sec_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .inj_en    (inj_en),
    .inj_bit   (inj_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_check (out_check),
    .word_cnt  (word_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference check bits, one data-bit mask per check bit.
  function automatic logic [7:0] enc(input logic [31:0] d);
    logic [31:0] m [8];
    logic [7:0]  c;
    m[0] = 32'h00FF1111; m[1] = 32'hFF002222; m[2] = 32'h0F0F4444; m[3] = 32'hF0F08888;
    m[4] = 32'h111100FF; m[5] = 32'h2222FF00; m[6] = 32'h44440F0F; m[7] = 32'h8888F0F0;
    for (int k = 0; k < 8; k++) c[k] = ^(d & m[k]);
    return c;
  endfunction

  // Downstream SEC corrector: locate the data column that matches the
  // syndrome and flip that bit. A check-bit error leaves the data as is.
  function automatic logic [31:0] correct(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  syn;
    logic [31:0] r;
    syn = c ^ enc(d);
    r   = d;
    if (syn != 8'h00) begin
      for (int i = 0; i < 32; i++) begin
        if (enc(32'h1 << i) == syn) r[i] = ~r[i];
      end
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [39:0] exp_q[$];
  logic [32:0] orig_q[$];
  logic        sb_on = 1'b0;
  int          acc_cnt = 0;
  int          hs_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [39:0] prev_code;

  // Sample at the falling edge; the transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (sb_on) begin
      if (prev_stall) begin
        check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
        check_eq("hold_code", {24'd0, out_check, out_data}, {24'd0, prev_code});
      end
      if (in_valid && in_ready) begin
        logic [39:0] cw;
        logic        inj;
        inj = inj_en && (inj_bit < 6'd40);
        cw  = {enc(in_data), in_data};
        if (inj) cw[inj_bit] = ~cw[inj_bit];
        exp_q.push_back(cw);
        orig_q.push_back({inj, in_data});
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected", {24'd0, out_check, out_data}, 64'hDEAD);
        end else begin
          logic [39:0] e;
          logic [32:0] o;
          e = exp_q.pop_front();
          o = orig_q.pop_front();
          check_eq("sb_code", {24'd0, out_check, out_data}, {24'd0, e});
          if (o[32]) check_eq("sb_corrected", {32'd0, correct(out_data, out_check)}, {32'd0, o[31:0]});
          else       check_eq("sb_syndrome", {56'd0, out_check ^ enc(out_data)}, 64'd0);
        end
        hs_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_code  = {out_check, out_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5A5A5; out_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  // Accepted at edge N: after edge N only S1 is full; after edge N+1 the
  // codeword is on the outputs and it transfers on edge N+2.
  task automatic send_check(input string tag, input logic [31:0] d, input logic ie,
                            input logic [5:0] ib, input logic [31:0] ed, input logic [7:0] ec);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; inj_en = ie; inj_bit = ib; out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; inj_en = 1'b0;
    @(negedge clk);
    check_eq({tag, "_early"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check_eq({tag, "_data"}, {32'd0, out_data}, {32'd0, ed});
    check_eq({tag, "_check"}, {56'd0, out_check}, {56'd0, ec});
  endtask

  localparam int TOTAL = 65537;
  localparam int RAND_WORDS = 10000;

  // Bound on total run time in case the DUT stalls forever.
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete, accepted=%0d handshakes=%0d", acc_cnt, hs_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; inj_en = 1'b0; inj_bit = '0; out_ready = 1'b0;

    // Reset values, in_ready right after release, nothing accepted during reset.
    do_reset();
    @(negedge clk);
    check_eq("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("post_rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("post_rst_cnt", {48'd0, word_cnt}, 64'd0);
    check_eq("post_rst_data", {32'd0, out_data}, 64'd0);
    check_eq("post_rst_check", {56'd0, out_check}, 64'd0);

    // Clean encodings.
    send_check("enc_d0",   32'h00000001, 1'b0, 6'd0, 32'h00000001, 8'h51);
    send_check("enc_d16",  32'h00010000, 1'b0, 6'd0, 32'h00010000, 8'h15);
    send_check("enc_ones", 32'hFFFFFFFF, 1'b0, 6'd0, 32'hFFFFFFFF, 8'h00);
    send_check("enc_zero", 32'h00000000, 1'b0, 6'd0, 32'h00000000, 8'h00);
    send_check("enc_d31",  32'h80000000, 1'b0, 6'd0, 32'h80000000, 8'h8A);
    send_check("enc_d8",   32'h00000100, 1'b0, 6'd0, 32'h00000100, 8'h61);

    // Injection, including the 31/32 and 39/40 boundaries and a disabled request.
    send_check("inj_5",    32'h00000000, 1'b1, 6'd5,  32'h00000020, 8'h00);
    send_check("inj_35",   32'h00000000, 1'b1, 6'd35, 32'h00000000, 8'h08);
    send_check("inj_40",   32'h00000000, 1'b1, 6'd40, 32'h00000000, 8'h00);
    send_check("inj_31",   32'h00000000, 1'b1, 6'd31, 32'h80000000, 8'h00);
    send_check("inj_32",   32'h00000000, 1'b1, 6'd32, 32'h00000000, 8'h01);
    send_check("inj_39",   32'h00000000, 1'b1, 6'd39, 32'h00000000, 8'h80);
    send_check("inj_63",   32'h00000000, 1'b1, 6'd63, 32'h00000000, 8'h00);
    send_check("inj_off",  32'h00000000, 1'b0, 6'd5,  32'h00000000, 8'h00);
    send_check("inj_d16",  32'h00010000, 1'b1, 6'd0,  32'h00010001, 8'h15);

    // Backpressure: A and B fill the pipe, C is refused until out_ready rises.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000000A;
    @(negedge clk);
    check_eq("bp_a_rdy", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1; in_data = 32'h0000000B;
    @(negedge clk);
    check_eq("bp_b_rdy", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1; in_data = 32'h0000000C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_c_refused", {63'd0, in_ready}, 64'd0);
      check_eq("bp_hold_a", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h0000000A});
      if (i < 2) @(posedge clk);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_c_rdy", {63'd0, in_ready}, 64'd1);
    check_eq("bp_out_a", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h0000000A});
    check_eq("bp_chk_a", {56'd0, out_check}, {56'd0, enc(32'h0000000A)});
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_out_b", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h0000000B});
    @(posedge clk); @(negedge clk);
    check_eq("bp_out_c", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h0000000C});
    @(posedge clk); @(negedge clk);
    check_eq("bp_empty", {63'd0, out_valid}, 64'd0);

    // Reset with both stages full discards them.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11111111;
    @(posedge clk); #1; in_data = 32'h22222222;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_full_rdy", {63'd0, in_ready}, 64'd0);
    check_eq("mid_full_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_rdy", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_eq("mid_after_valid", {63'd0, out_valid}, 64'd0);
    check_eq("mid_after_cnt", {48'd0, word_cnt}, 64'd0);
    check_eq("mid_after_rdy", {63'd0, in_ready}, 64'd1);
    send_check("mid_next", 32'h00000001, 1'b0, 6'd0, 32'h00000001, 8'h51);

    // Long stream: random backpressure first, then full rate up to the wrap.
    do_reset();
    sb_on = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (acc_cnt >= TOTAL) begin
        in_valid = 1'b0; inj_en = 1'b0;
        break;
      end
      in_data = $urandom;
      inj_en  = ($urandom_range(0, 3) == 0);
      inj_bit = 6'($urandom_range(0, 63));
      if (acc_cnt < RAND_WORDS) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b1;
        out_ready = 1'b1;
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    sb_on = 1'b0;
    check_eq("wrap_hs", 64'(hs_cnt), 64'(TOTAL));
    check_eq("wrap_cnt", {48'd0, word_cnt}, 64'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
